demux4_stream: RTL

- Sequential 1-to-4 demultiplexer with registered outputs; the inverse of the 4:1 MUX datapath.
- Routes one input word to one of four output channels chosen by a 2-bit select ({b,a}).
- Each channel has its own one-entry holding register and a valid/ready handshake.
- Used in front of per-destination consumers: writeback ports, peripheral lanes, and the MUX benches as a stimulus source.

---
 rtl/demux4_stream.sv | 120 ++++++++++++
 1 files changed

// File: rtl/demux4_stream.sv
// demux4_stream: registered 1-to-4 stream demultiplexer.
// Each input word goes to channel {b,a}. Every channel has a one-entry holding
// register with its own valid/ready handshake.
// Optional per-channel handshake counters are enabled by defining DEMUX4_COUNT_EN.
// Without that macro, count reads as zero and no counter flops exist.
module demux4_stream #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               a,
  input  logic               b,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [31:0]        count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

  chan_state_t      state_q [4];
  chan_state_t      state_d [4];
  logic [WIDTH-1:0] data_q  [4];
  logic [3:0]       load;
  logic [3:0]       drain;
  logic [1:0]       sel;
  logic             accept;

  assign sel    = {b, a};
  assign accept = in_valid && in_ready;

  // Only the selected channel can block the input; a full channel that is
  // being drained this cycle can take a new word in the same cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = (state_q[sel] == EMPTY) || out_ready[sel];
    end
  end

  // Per-channel next state: a load wins over a drain, so drain+reload stays FULL.
  always_comb begin
    load  = '0;
    drain = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      load[i]    = accept && (sel == 2'(i));
      drain[i]   = (state_q[i] == FULL) && out_ready[i];
      if (load[i]) begin
        state_d[i] = FULL;
      end else if (drain[i]) begin
        state_d[i] = EMPTY;
      end
    end
  end

  // Channel state and holding registers. Reset discards held words,
  // even when a handshake is pending in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        if (load[i]) begin
          data_q[i] <= in_data;
        end
      end
    end
  end

  // Flatten the per-channel registers onto the output buses.
  always_comb begin
    out_data  = '0;
    out_valid = '0;
    for (int i = 0; i < 4; i++) begin
      out_data[i*WIDTH +: WIDTH] = data_q[i];
      out_valid[i]               = (state_q[i] == FULL);
    end
  end

`ifdef DEMUX4_COUNT_EN
  logic [7:0] cnt_q [4];

  // Count output handshakes per channel; the 8-bit counters wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (drain[i]) begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Pack the counters onto the count bus.
  always_comb begin
    count = '0;
    for (int i = 0; i < 4; i++) begin
      count[i*8 +: 8] = cnt_q[i];
    end
  end
`else
  assign count = 32'h0;
`endif

endmodule
